// File: rtl/alu_writeback_regfile.sv
// Purpose : 16x16 register file (2 async read ports, 1 sync write port) plus a
//           5-bit processor status register with branch/jump condition decode.
// Latency : reads 0 cycles; writes and flag updates visible after the capturing edge.
// Backpressure: none; one write and one flag update accepted every cycle.
//
// Ports:
//   clk, reset_n            - single rising-edge clock, synchronous active-low reset
//   rd_addr_a/b, rd_data_a/b - combinational read ports feeding ALU A/B
//   wr_en, wr_addr, wr_data - write port committing ALU result C
//   flags_en, flags_in      - status latch of ALU Flags {Z,C,F,N,L} (bit 4..0)
//   psr                     - registered status
//   cond, cond_true         - condition code and its evaluation against status
//
// Optional feature: define ALU_WB_BYPASS_EN to forward the write data and the
// incoming flags to the read ports / condition decode in the same cycle.

module alu_writeback_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flags_en,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [FLAG_W-1:0] psr,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Status bit positions
    localparam int Z_BIT = 4;
    localparam int C_BIT = 3;
    localparam int F_BIT = 2;
    localparam int N_BIT = 1;
    localparam int L_BIT = 0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [FLAG_W-1:0] cond_flags;

    // Storage: reset clears everything and overrides any write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            psr <= '0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (flags_en) begin
                psr <= flags_in;
            end
        end
    end

`ifdef ALU_WB_BYPASS_EN
    // Forwarding is suppressed during reset so reads show the cleared state.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        cond_flags = psr;
        if (reset_n && wr_en && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (reset_n && wr_en && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
        if (reset_n && flags_en) begin
            cond_flags = flags_in;
        end
    end
`else
    always_comb begin
        rd_data_a  = regs[rd_addr_a];
        rd_data_b  = regs[rd_addr_b];
        cond_flags = psr;
    end
`endif

    // Condition decode
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true =  cond_flags[Z_BIT];
            4'b0001: cond_true = ~cond_flags[Z_BIT];
            4'b0010: cond_true =  cond_flags[C_BIT];
            4'b0011: cond_true = ~cond_flags[C_BIT];
            4'b0100: cond_true =  cond_flags[L_BIT];
            4'b0101: cond_true = ~cond_flags[L_BIT];
            4'b0110: cond_true =  cond_flags[N_BIT];
            4'b0111: cond_true = ~cond_flags[N_BIT];
            4'b1000: cond_true =  cond_flags[F_BIT];
            4'b1001: cond_true = ~cond_flags[F_BIT];
            4'b1010: cond_true = ~cond_flags[L_BIT] & ~cond_flags[Z_BIT];
            4'b1011: cond_true =  cond_flags[L_BIT] |  cond_flags[Z_BIT];
            4'b1100: cond_true = ~cond_flags[N_BIT] & ~cond_flags[Z_BIT];
            4'b1101: cond_true =  cond_flags[N_BIT] |  cond_flags[Z_BIT];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Purpose : self-checking bench for alu_writeback_regfile with a behavioural
//           model (array + status word) compared on every falling edge, plus
//           directed literal expectations and a randomized phase.
// Latency : inputs driven 1 time unit after the rising edge, sampled on the falling edge.

module tb_alu_writeback_regfile;

    logic        clk;
    logic        reset_n;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flags_en;
    logic [4:0]  flags_in;
    logic [4:0]  psr;
    logic [3:0]  cond;
    logic        cond_true;

    int checks = 0;
    int errors = 0;

    alu_writeback_regfile #(.DATA_W(16), .ADDR_W(4), .FLAG_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flags_en  (flags_en),
        .flags_in  (flags_in),
        .psr       (psr),
        .cond      (cond),
        .cond_true (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;
    bit          m_valid = 0;

`ifdef ALU_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Conditions come in complementary pairs: even code tests a predicate,
    // odd code is its negation.
    function automatic logic model_cond(input logic [3:0] c, input logic [4:0] f);
        logic z, cy, ov, n, l, p;
        z = f[4]; cy = f[3]; ov = f[2]; n = f[1]; l = f[0];
        case (c[3:1])
            3'd0:    p = z;
            3'd1:    p = cy;
            3'd2:    p = l;
            3'd3:    p = n;
            3'd4:    p = ov;
            3'd5:    p = !l && !z;
            3'd6:    p = !n && !z;
            default: p = 1'b1;
        endcase
        return p ^ c[0];
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
            m_psr   = 5'h00;
            m_valid = 1;
        end else if (m_valid) begin
            if (wr_en)    m_regs[wr_addr] = wr_data;
            if (flags_en) m_psr = flags_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [15:0] ea, eb;
            logic [4:0]  ef;
            ea = m_regs[rd_addr_a];
            eb = m_regs[rd_addr_b];
            ef = m_psr;
            if (BYPASS && reset_n && wr_en && rd_addr_a == wr_addr) ea = wr_data;
            if (BYPASS && reset_n && wr_en && rd_addr_b == wr_addr) eb = wr_data;
            if (BYPASS && reset_n && flags_en) ef = flags_in;
            chk("model_rd_a", {16'h0, rd_data_a}, {16'h0, ea});
            chk("model_rd_b", {16'h0, rd_data_b}, {16'h0, eb});
            chk("model_psr", {27'h0, psr}, {27'h0, m_psr});
            chk("model_cond", {31'h0, cond_true}, {31'h0, model_cond(cond, ef)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived cond_true masks (bit k = result for cond k).
    logic [4:0]  sweep_psr  [7] = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
    logic [15:0] sweep_mask [7] = '{16'h56AA, 16'h5A9A, 16'h666A, 16'h55AA,
                                    16'h56A6, 16'h6AA9, 16'h6955};

    initial begin
        logic [15:0] exp_v;
        logic [15:0] mask;
        reset_n = 1'b0; rd_addr_a = '0; rd_addr_b = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; flags_en = 1'b0; flags_in = '0; cond = 4'b0001;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state on all addresses
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            cond = 4'b0001;
            @(negedge clk);
            chk("reset_rd_a", {16'h0, rd_data_a}, 32'h0);
            chk("reset_rd_b", {16'h0, rd_data_b}, 32'h0);
            chk("reset_psr", {27'h0, psr}, 32'h0);
            chk("reset_ne", {31'h0, cond_true}, 32'h1);
            tick();
        end

        // Two writes, then read back everything
        wr_en = 1'b1; wr_addr = 4'd5;  wr_data = 16'hBEEF; tick();
        wr_addr = 4'd12; wr_data = 16'h1234; tick();
        wr_en = 1'b0;
        rd_addr_a = 4'd5; rd_addr_b = 4'd12;
        @(negedge clk);
        chk("wr_r5", {16'h0, rd_data_a}, 32'hBEEF);
        chk("wr_r12", {16'h0, rd_data_b}, 32'h1234);
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            exp_v = (i == 5) ? 16'hBEEF : (i == 12) ? 16'h1234 : 16'h0000;
            @(negedge clk);
            chk("wr_others", {16'h0, rd_data_a}, {16'h0, exp_v});
            tick();
        end

        // Same-cycle read of write target
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hAAAA; rd_addr_a = 4'd3;
        @(negedge clk);
        chk("same_cycle_rd", {16'h0, rd_data_a}, BYPASS ? 32'hAAAA : 32'h0000);
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("after_edge_rd", {16'h0, rd_data_a}, 32'hAAAA);
        tick();

        // Flag latch and hold
        flags_en = 1'b1; flags_in = 5'b10000; tick();
        flags_en = 1'b0; flags_in = 5'b00000;
        cond = 4'b0000; @(negedge clk);
        chk("psr_latch", {27'h0, psr}, 32'h10);
        chk("cond_eq", {31'h0, cond_true}, 32'h1);
        tick();
        cond = 4'b1011; @(negedge clk); chk("cond_hs", {31'h0, cond_true}, 32'h1); tick();
        cond = 4'b1101; @(negedge clk); chk("cond_ge", {31'h0, cond_true}, 32'h1); tick();
        cond = 4'b0001; @(negedge clk); chk("cond_ne", {31'h0, cond_true}, 32'h0); tick();
        chk("psr_hold", {27'h0, psr}, 32'h10);

        // Reset dominates write and flag update
        reset_n = 1'b0; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hFFFF;
        flags_en = 1'b1; flags_in = 5'h1F;
        tick();
        reset_n = 1'b1; wr_en = 1'b0; flags_en = 1'b0; flags_in = 5'h00;
        rd_addr_a = 4'd7; rd_addr_b = 4'd5;
        @(negedge clk);
        chk("rst_r7", {16'h0, rd_data_a}, 32'h0);
        chk("rst_r5", {16'h0, rd_data_b}, 32'h0);
        chk("rst_psr", {27'h0, psr}, 32'h0);
        tick();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hFFFF; tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("post_rst_r7", {16'h0, rd_data_a}, 32'hFFFF);
        tick();

        // Condition sweep against hand-computed masks
        for (int p = 0; p < 7; p++) begin
            flags_en = 1'b1; flags_in = sweep_psr[p]; tick();
            flags_en = 1'b0;
            mask = sweep_mask[p];
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                @(negedge clk);
                chk("sweep_cond", {31'h0, cond_true}, {31'h0, mask[c]});
                tick();
            end
        end

        // Randomized traffic, model checked every cycle
        for (int n = 0; n < 3000; n++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            wr_en     = ($urandom_range(0, 2) != 0);
            flags_en  = ($urandom_range(0, 1) != 0);
            wr_addr   = 4'($urandom_range(0, 15));
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 4'($urandom_range(0, 15));
            wr_data   = 16'($urandom);
            flags_in  = 5'($urandom_range(0, 31));
            cond      = 4'($urandom_range(0, 15));
            tick();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
